lfsr_tap_selector: RTL and testbench
====================================

// Module: lfsr_tap_selector
// PURPOSE
//   Builds a packed set of LFSR tap positions from a stream of random bytes. Rejects zero,
//   out-of-range and in-group duplicate candidates. Optionally forces the top tap (SIZE-1)
//   into the set, then holds the result with a done flag.
//   Sits between the random byte source and the LFSR bank; generalises the fixed 8-tap
//   selector to any group count and size, any register length, and a restart path.
// PARAMETERS
//   NUM_GROUPS  5   number of tap groups (one group = taps feeding one LFSR)
//   GROUP_SIZE  3   taps per group; NUM_TAPS = NUM_GROUPS*GROUP_SIZE
//   SIZE        32  LFSR length; legal tap values 1..SIZE-1; 2 <= SIZE <= 256
//   TAP_W       8   width of one tap slot in taps; TAP_W >= IDX_W = clog2(SIZE)
//   FORCE_MAX   1   1: guarantee SIZE-1 appears in the set (fixup step); 0: no fixup
// PORTS
//   clk      in   1               clock, all logic on rising edge
//   res      in   1               synchronous active-high reset
//   ena      in   1               clock enable; 0 freezes all state (except res/start)
//   start    in   1               synchronous restart: clear set, re-collect (res has priority)
//   take     in   1               din valid this cycle
//   din      in   8               random byte; candidate c = din[IDX_W-1:0]
//   taps     out  NUM_TAPS*TAP_W  slot k at [(k+1)*TAP_W-1 -: TAP_W], zero-extended
//   done     out  1               level, set is complete and stable
//   busy     out  1               1 in COLLECT/FIXUP
//   rej_cnt  out  16              rejected candidates since reset/start, saturates at 0xFFFF
// BEHAVIOUR
//   - Reset (res=1 at edge): taps=0, slot count=0, rej_cnt=0, done=0, busy=1, state=COLLECT.
//   - start=1 at edge (res=0): identical clear, regardless of ena or state.
//   - States: COLLECT -> FIXUP -> DONE. DONE exits only via res or start.
//   - COLLECT, edge with ena&&take: candidate c is accepted iff all of:
//     * c != 0
//     * c < SIZE
//     * c differs from every already-filled slot of the current group,
//       where group = count / GROUP_SIZE.
//     Duplicates across different groups are legal.
//   - Accept: slot[count] <= c, count++; value visible on taps the cycle after the edge.
//   - Reject: slot and count unchanged, rej_cnt++ (saturating); no other effect.
//   - When the accept fills slot NUM_TAPS-1, state -> FIXUP on that same edge.
//   - FIXUP (one enabled edge):
//     * FORCE_MAX=1 and no slot holds SIZE-1: slot 0 <= SIZE-1.
//       If slot 0 then duplicates another slot in group 0, the duplicate slot is left as-is
//       (accepted limitation); verify with group 0 free of SIZE-1 only.
//     * State -> DONE, done=1, busy=0. done is high one enabled cycle after the last tap appears.
//   - DONE: take/din ignored, rej_cnt frozen, taps stable.
//   - ena=0: no accept/reject/fixup/state change; take ignored (sample lost, not queued).
//   - Simultaneous res and start: res wins (same result).
//   - start during DONE: done falls the next cycle.
//   - Reset mid-collect discards partial set.
// TESTING
//   1 res, then take din=0x00,0x05,0x25,0x07,0x09 -> slots0..2=5,7,9; rej_cnt=2 (zero, dup 5).
//   2 group1 fed 0x05,0x07,0x0B -> accepted (cross-group dup legal); slots3..5=5,7,11.
//   3 fill 15 taps none =31, FORCE_MAX=1 -> one cycle after slot14 written, slot0=31, done=1.
//   4 SIZE=24: din=0x1A (26) -> rejected, rej_cnt+1; din=0x17 (23) -> accepted.
//   5 ena=0 with take=1, din=0x03 for 4 cycles -> taps, count, rej_cnt unchanged.
//   6 start at count=8 -> next cycle taps=0, rej_cnt=0, busy=1; res+start together -> reset state.

Source files
------------

// File: rtl/lfsr_tap_selector.sv
// lfsr_tap_selector
// Collects NUM_GROUPS*GROUP_SIZE LFSR tap positions from a stream of random
// bytes. A candidate is rejected when it is zero, not below SIZE, or already
// present in the group currently being filled. Once every slot is filled, one
// fixup step can force SIZE-1 into slot 0. The set is then held with done high
// until res or start clears it.
module lfsr_tap_selector #(
    parameter int NUM_GROUPS = 5,
    parameter int GROUP_SIZE = 3,
    parameter int SIZE       = 32,
    parameter int TAP_W      = 8,
    parameter int FORCE_MAX  = 1
) (
    input  logic                                    clk,
    input  logic                                    res,
    input  logic                                    ena,
    input  logic                                    start,
    input  logic                                    take,
    input  logic [7:0]                              din,
    output logic [NUM_GROUPS*GROUP_SIZE*TAP_W-1:0]  taps,
    output logic                                    done,
    output logic                                    busy,
    output logic [15:0]                             rej_cnt
);

    localparam int NUM_TAPS = NUM_GROUPS * GROUP_SIZE;
    localparam int IDX_W    = $clog2(SIZE);
    localparam int CNT_W    = $clog2(NUM_TAPS + 1);

    localparam logic [IDX_W:0]   SIZE_EXT = (IDX_W + 1)'(SIZE);
    localparam logic [IDX_W-1:0] MAX_TAP  = IDX_W'(SIZE - 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TAPS - 1);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_FIXUP   = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    // The duplicate and "SIZE-1 present" checks compare every slot in
    // parallel, so the slots are kept in registers rather than in a RAM.
    logic [IDX_W-1:0] slot_reg [NUM_TAPS];
    logic [CNT_W-1:0] count_reg, count_next;
    logic [1:0]       state_reg, state_next;
    logic [15:0]      rej_reg, rej_next;

    logic             clear;
    logic [IDX_W-1:0] cand;
    logic             cand_ok;
    logic [CNT_W-1:0] group_base;
    logic [NUM_TAPS-1:0] dup_bits;
    logic [NUM_TAPS-1:0] max_bits;

    logic             slot_we;
    logic [CNT_W-1:0] slot_widx;
    logic [IDX_W-1:0] slot_wval;

    // Only the low IDX_W bits of din form the candidate.
    logic unused_din_bits;
    assign unused_din_bits = ^din;

    assign clear = res | start;
    assign cand  = din[IDX_W-1:0];

    // Group currently being filled starts at the last multiple of GROUP_SIZE.
    always_comb begin
        group_base = CNT_W'((int'(count_reg) / GROUP_SIZE) * GROUP_SIZE);
    end

    generate
        for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_slot
            // A slot blocks the candidate only if it is filled and in the current group.
            assign dup_bits[gi] = (CNT_W'(gi) >= group_base) &&
                                  (CNT_W'(gi) < count_reg) &&
                                  (slot_reg[gi] == cand);
            // Unfilled slots hold 0 and MAX_TAP >= 1, so they never match.
            assign max_bits[gi] = (slot_reg[gi] == MAX_TAP);

            assign taps[(gi+1)*TAP_W-1 -: TAP_W] = TAP_W'(slot_reg[gi]);

            // Slot storage: cleared on res/start, written on accept or fixup.
            always_ff @(posedge clk) begin
                if (clear) begin
                    slot_reg[gi] <= '0;
                end else if (slot_we && (slot_widx == CNT_W'(gi))) begin
                    slot_reg[gi] <= slot_wval;
                end
            end
        end
    endgenerate

    assign cand_ok = (cand != '0) && ({1'b0, cand} < SIZE_EXT) && (dup_bits == '0);

    // Decide accept/reject/fixup and the next state for an enabled edge.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        rej_next   = rej_reg;
        slot_we    = 1'b0;
        slot_widx  = count_reg;
        slot_wval  = cand;
        if (ena) begin
            case (state_reg)
                ST_COLLECT: begin
                    if (take) begin
                        if (cand_ok) begin
                            slot_we    = 1'b1;
                            count_next = count_reg + 1'b1;
                            if (count_reg == LAST_IDX) begin
                                state_next = ST_FIXUP;
                            end
                        end else if (rej_reg != 16'hFFFF) begin
                            rej_next = rej_reg + 16'd1;
                        end
                    end
                end
                ST_FIXUP: begin
                    if ((FORCE_MAX != 0) && (max_bits == '0)) begin
                        slot_we   = 1'b1;
                        slot_widx = '0;
                        slot_wval = MAX_TAP;
                    end
                    state_next = ST_DONE;
                end
                ST_DONE: begin
                    state_next = ST_DONE;
                end
                default: begin
                    state_next = ST_COLLECT;
                end
            endcase
        end
    end

    // Control registers; res and start both restart collection regardless of ena.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg <= ST_COLLECT;
            count_reg <= '0;
            rej_reg   <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            rej_reg   <= rej_next;
        end
    end

    assign done    = (state_reg == ST_DONE);
    assign busy    = (state_reg != ST_DONE);
    assign rej_cnt = rej_reg;

endmodule

// File: tb/tb_lfsr_tap_selector.sv
// Bench for lfsr_tap_selector: two instances (SIZE=32 and SIZE=24) share one
// directed input stream. A set-based model predicts every output each cycle,
// and hand-computed literal expectations pin the model at key points.
module tb_lfsr_tap_selector;

    localparam int NT = 15;
    localparam int TW = NT * 8;

    logic clk = 1'b0;
    logic res, ena, start, take;
    logic [7:0] din;

    logic [TW-1:0] taps_a, taps_b;
    logic done_a, done_b, busy_a, busy_b;
    logic [15:0] rej_a, rej_b;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    lfsr_tap_selector #(.NUM_GROUPS(5), .GROUP_SIZE(3), .SIZE(32), .TAP_W(8), .FORCE_MAX(1)) dut_a (
        .clk(clk), .res(res), .ena(ena), .start(start), .take(take), .din(din),
        .taps(taps_a), .done(done_a), .busy(busy_a), .rej_cnt(rej_a)
    );

    lfsr_tap_selector #(.NUM_GROUPS(5), .GROUP_SIZE(3), .SIZE(24), .TAP_W(8), .FORCE_MAX(1)) dut_b (
        .clk(clk), .res(res), .ena(ena), .start(start), .take(take), .din(din),
        .taps(taps_b), .done(done_b), .busy(busy_b), .rej_cnt(rej_b)
    );

    // ---------------- model: accepted taps as a list, phase 0/1/2 ----------------
    int m_tap   [2][NT];
    int m_cnt   [2];
    int m_rej   [2];
    int m_phase [2];   // 0 collecting, 1 fixup pending, 2 complete

    function automatic int inst_size(input int i);
        return (i == 0) ? 32 : 24;
    endfunction

    function automatic int idx_mask(input int sz);
        int m = 1;
        while (m < sz) m = m * 2;
        return m - 1;
    endfunction

    task automatic model_clear(input int i);
        for (int k = 0; k < NT; k++) m_tap[i][k] = 0;
        m_cnt[i] = 0;
        m_rej[i] = 0;
        m_phase[i] = 0;
    endtask

    task automatic model_step(input int i);
        int sz, c, lo;
        bit seen;
        sz = inst_size(i);
        if (res || start) begin
            model_clear(i);
        end else if (ena) begin
            if (m_phase[i] == 0) begin
                if (take) begin
                    c = int'(din) & idx_mask(sz);
                    lo = (m_cnt[i] / 3) * 3;
                    seen = 1'b0;
                    for (int k = lo; k < m_cnt[i]; k++) if (m_tap[i][k] == c) seen = 1'b1;
                    if (c != 0 && c < sz && !seen) begin
                        m_tap[i][m_cnt[i]] = c;
                        m_cnt[i]++;
                        if (m_cnt[i] == NT) m_phase[i] = 1;
                    end else if (m_rej[i] < 65535) begin
                        m_rej[i]++;
                    end
                end
            end else if (m_phase[i] == 1) begin
                seen = 1'b0;
                for (int k = 0; k < NT; k++) if (m_tap[i][k] == sz - 1) seen = 1'b1;
                if (!seen) m_tap[i][0] = sz - 1;
                m_phase[i] = 2;
            end
        end
    endtask

    initial begin
        model_clear(0);
        model_clear(1);
    end

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    // ---------------- comparison helper ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                logic [TW-1:0] exp_taps;
                exp_taps = '0;
                for (int k = 0; k < NT; k++) exp_taps[k*8 +: 8] = 8'(m_tap[i][k]);
                if (i == 0) begin
                    chk("model_taps_a", 128'(taps_a), 128'(exp_taps));
                    chk("model_done_a", 128'(done_a), 128'(m_phase[0] == 2));
                    chk("model_busy_a", 128'(busy_a), 128'(m_phase[0] != 2));
                    chk("model_rej_a",  128'(rej_a),  128'(m_rej[0]));
                end else begin
                    chk("model_taps_b", 128'(taps_b), 128'(exp_taps));
                    chk("model_done_b", 128'(done_b), 128'(m_phase[1] == 2));
                    chk("model_busy_b", 128'(busy_b), 128'(m_phase[1] != 2));
                    chk("model_rej_b",  128'(rej_b),  128'(m_rej[1]));
                end
            end
        end
    end

    // One transaction: drive inputs just after a falling edge, wait one cycle.
    task automatic step(input bit t, input logic [7:0] d);
        take = t;
        din  = d;
        @(negedge clk);
        $display("txn t=%0t res=%0b start=%0b ena=%0b take=%0b din=%02h | a:rej=%0d done=%0b b:rej=%0d done=%0b",
                 $time, res, start, ena, t, d, rej_a, done_a, rej_b, done_b);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        res = 1'b1; start = 1'b0; ena = 1'b1; take = 1'b0; din = 8'h00;
        @(negedge clk);
        chk_on = 1'b1;
        step(1'b0, 8'h00);
        res = 1'b0;
        step(1'b0, 8'h00);

        // Reset state
        chk("rst_taps", 128'(taps_a), 128'(0));
        chk("rst_rej",  128'(rej_a),  128'(0));
        chk("rst_done", 128'(done_a), 128'(0));
        chk("rst_busy", 128'(busy_a), 128'(1));

        // Test 1: zero and in-group duplicate rejected
        step(1'b1, 8'h00); step(1'b1, 8'h05); step(1'b1, 8'h25);
        step(1'b1, 8'h07); step(1'b1, 8'h09);
        chk("t1_slots_a", 128'(taps_a[23:0]), 128'(24'h090705));
        chk("t1_rej_a",   128'(rej_a), 128'(2));
        chk("t1_slots_b", 128'(taps_b[23:0]), 128'(24'h090705));

        // Test 2: cross-group duplicates accepted
        step(1'b1, 8'h05); step(1'b1, 8'h07); step(1'b1, 8'h0B);
        chk("t2_slots_a", 128'(taps_a[47:24]), 128'(24'h0B0705));
        chk("t2_rej_a",   128'(rej_a), 128'(2));

        // Test 5: ena low drops samples
        ena = 1'b0;
        for (int n = 0; n < 4; n++) step(1'b1, 8'h03);
        chk("t5_taps_a", 128'(taps_a), 128'(48'h0B0705090705));
        chk("t5_rej_a",  128'(rej_a), 128'(2));
        ena = 1'b1;

        // Test 6: start at count 8, then res+start together
        step(1'b1, 8'h0C); step(1'b1, 8'h0D);
        chk("t6_pre_slot7", 128'(taps_a[63:56]), 128'(8'h0D));
        start = 1'b1;
        step(1'b0, 8'h00);
        start = 1'b0;
        chk("t6_start_taps", 128'(taps_a), 128'(0));
        chk("t6_start_rej",  128'(rej_a), 128'(0));
        chk("t6_start_busy", 128'(busy_a), 128'(1));
        step(1'b1, 8'h01); step(1'b1, 8'h00);
        chk("t6_refill_rej", 128'(rej_a), 128'(1));
        res = 1'b1; start = 1'b1;
        step(1'b0, 8'h00);
        res = 1'b0; start = 1'b0;
        chk("t6_both_taps", 128'(taps_a), 128'(0));
        chk("t6_both_rej",  128'(rej_a), 128'(0));

        // Test 3: fill 1..15, fixup forces SIZE-1 into slot 0
        for (int v = 1; v <= 15; v++) step(1'b1, 8'(v));
        chk("t3_last_slot",  128'(taps_a[119:112]), 128'(8'd15));
        chk("t3_done_early", 128'(done_a), 128'(0));
        chk("t3_slot0_pre",  128'(taps_a[7:0]), 128'(8'd1));
        step(1'b0, 8'h00);
        chk("t3_done_a",  128'(done_a), 128'(1));
        chk("t3_busy_a",  128'(busy_a), 128'(0));
        chk("t3_slot0_a", 128'(taps_a[7:0]), 128'(8'd31));
        chk("t3_slot0_b", 128'(taps_b[7:0]), 128'(8'd23));
        step(1'b1, 8'h00); step(1'b1, 8'h05);
        chk("t3_hold_rej",  128'(rej_a), 128'(0));
        chk("t3_hold_slot", 128'(taps_a[15:0]), 128'(16'h021F));

        // start during DONE: done falls next cycle
        start = 1'b1;
        step(1'b0, 8'h00);
        start = 1'b0;
        chk("restart_done", 128'(done_a), 128'(0));
        chk("restart_busy", 128'(busy_a), 128'(1));

        // Test 4: out-of-range on SIZE=24
        step(1'b1, 8'h1A); step(1'b1, 8'h17);
        chk("t4_rej_b",   128'(rej_b), 128'(1));
        chk("t4_slot0_b", 128'(taps_b[7:0]), 128'(8'd23));
        chk("t4_slots_a", 128'(taps_a[15:0]), 128'(16'h171A));
        chk("t4_rej_a",   128'(rej_a), 128'(0));

        // SIZE-1 already present: no fixup on instance A
        start = 1'b1;
        step(1'b0, 8'h00);
        start = 1'b0;
        for (int v = 1; v <= 14; v++) step(1'b1, 8'(v));
        step(1'b1, 8'h1F);
        step(1'b1, 8'h14);
        step(1'b0, 8'h00);
        chk("nofix_done_a",  128'(done_a), 128'(1));
        chk("nofix_slot0_a", 128'(taps_a[7:0]), 128'(8'd1));
        chk("nofix_last_a",  128'(taps_a[119:112]), 128'(8'd31));
        chk("fix_done_b",    128'(done_b), 128'(1));
        chk("fix_slot0_b",   128'(taps_b[7:0]), 128'(8'd23));
        chk("fix_last_b",    128'(taps_b[119:112]), 128'(8'd20));
        chk("fix_rej_b",     128'(rej_b), 128'(1));

        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
